// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit: issues word-aligned data-memory requests with byte enables,
// formats load data and stalls the pipeline until memory acknowledges. Optional: LSU_MISALIGN_CHECK_EN.
module lsu_mem_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] ALUResult,
    input  logic [31:0] StoreData,
    output logic        Stall,
    output logic [31:0] LoadData,
    output logic        MemDone,
    output logic        MemErr,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_q, state_d;
    logic        req_q, req_d, we_q, we_d, err_q, err_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, ld_q, ld_d;
    logic [3:0]  be_q, be_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  a_q, a_d;

    logic        is_op, is_st, legal, misalign;
    logic [1:0]  a;
    logic [3:0]  be_n;
    logic [31:0] wdata_n, fmt;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Request decode from the EX/MEM inputs
    always_comb begin
        is_op = MemRead | MemWrite;
        is_st = MemWrite;
        a     = ALUResult[1:0];
        case (funct3)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = ~is_st;
            default:                legal = 1'b0;
        endcase
`ifdef LSU_MISALIGN_CHECK_EN
        misalign = ((funct3[1:0] == 2'b01) && a[0]) || ((funct3[1:0] == 2'b10) && (a != 2'b00));
`else
        misalign = 1'b0;
`endif
        case (funct3[1:0])
            2'b00: begin
                be_n    = 4'b0001 << a;
                wdata_n = {4{StoreData[7:0]}};
            end
            2'b01: begin
                be_n    = a[1] ? 4'b1100 : 4'b0011;
                wdata_n = {2{StoreData[15:0]}};
            end
            default: begin
                be_n    = 4'b1111;
                wdata_n = StoreData;
            end
        endcase
    end

    // Load lane selection and extension, using the attributes latched at issue
    always_comb begin
        case (a_q)
            2'b00:   byte_sel = dmem_rdata[7:0];
            2'b01:   byte_sel = dmem_rdata[15:8];
            2'b10:   byte_sel = dmem_rdata[23:16];
            default: byte_sel = dmem_rdata[31:24];
        endcase
        half_sel = a_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (f3_q)
            3'b000:  fmt = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  fmt = {{16{half_sel[15]}}, half_sel};
            3'b100:  fmt = {24'd0, byte_sel};
            3'b101:  fmt = {16'd0, half_sel};
            default: fmt = dmem_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        ld_d    = ld_q;
        err_d   = err_q;
        f3_d    = f3_q;
        a_d     = a_q;
        Stall   = 1'b0;
        case (state_q)
            IDLE: begin
                if (is_op) begin
                    Stall = 1'b1;
                    if (legal && !misalign) begin
                        req_d   = 1'b1;
                        we_d    = is_st;
                        addr_d  = {ALUResult[31:2], 2'b00};
                        be_d    = be_n;
                        wdata_d = wdata_n;
                        f3_d    = funct3;
                        a_d     = a;
                        err_d   = 1'b0;
                        state_d = BUSY;
                    end else begin
                        err_d   = 1'b1;
                        ld_d    = 32'd0;
                        state_d = DONE;
                    end
                end
            end
            BUSY: begin
                Stall = 1'b1;
                if (dmem_ack) begin
                    req_d = 1'b0;
                    we_d  = 1'b0;
                    if (!we_q) begin
                        ld_d = fmt;
                    end
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            be_q    <= 4'd0;
            wdata_q <= 32'd0;
            ld_q    <= 32'd0;
            err_q   <= 1'b0;
            f3_q    <= 3'd0;
            a_q     <= 2'd0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            ld_q    <= ld_d;
            err_q   <= err_d;
            f3_q    <= f3_d;
            a_q     <= a_d;
        end
    end

    assign MemDone    = (state_q == DONE);
    assign MemErr     = (state_q == DONE) && err_q;
    assign LoadData   = ld_q;
    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_be    = be_q;
    assign dmem_wdata = wdata_q;
endmodule

// File: doc/lsu_mem_stage.md
# lsu_mem_stage

Load/store unit for the MEM stage of the five-stage RISC-V core. It consumes the effective address computed by the EX-stage ALU (its `ALUResult`, latched in EX/MEM), generates a word-aligned data-memory request with byte enables, and waits for memory acknowledge. It sign- or zero-extends load data and stalls the pipeline until the access completes.

## Interface
Parameters:
- none. All widths are fixed: 32-bit data and addresses, 4 byte lanes.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `MemRead`  in  1  EX/MEM holds a load.
- `MemWrite`  in  1  EX/MEM holds a store. If both are high, the op is a store.
- `funct3`  in  3  access type:
  - loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
  - stores: 000 SB, 001 SH, 010 SW
- `ALUResult`  in  32  effective byte address.
- `StoreData`  in  32  rs2 value; the low byte or halfword is used for SB/SH.
- `Stall`  out  1  combinational; freezes PC, IF/ID, ID/EX and EX/MEM.
- `LoadData`  out  32  registered, extended load result.
- `MemDone`  out  1  one-cycle pulse; the op completes this cycle.
- `MemErr`  out  1  one-cycle pulse coincident with `MemDone`; access was not performed.
- `dmem_req`  out  1  registered memory request.
- `dmem_we`  out  1  registered write enable.
- `dmem_addr`  out  32  registered address, `{ALUResult[31:2],2'b00}`.
- `dmem_be`  out  4  registered byte enables.
- `dmem_wdata`  out  32  registered lane-replicated store data.
- `dmem_rdata`  in  32  read word, valid when `dmem_ack`=1.
- `dmem_ack`  in  1  memory completes the request this cycle.

## Operation
The controller is an FSM with three states: IDLE, BUSY, DONE. Reset enters IDLE.

- **IDLE**
  - With no op (`MemRead|MemWrite`=0): `Stall`=0 and the state stays IDLE.
  - With a legal op: `Stall`=1. Register the `dmem_*` outputs, set `dmem_req`=1, and go to BUSY.
  - With an illegal op (bad funct3, or misaligned when the check is enabled): `Stall`=1, no request is issued, set the error flag, and go to DONE.
- **BUSY**
  - `Stall`=1, and the `dmem_*` outputs are held stable.
  - On `dmem_ack`=1: drop `dmem_req`/`dmem_we` at the next edge, and capture the formatted `dmem_rdata` into `LoadData` (loads only). Then go to DONE.
  - Without an ack, stay in BUSY indefinitely. There is no timeout.
- **DONE**
  - `Stall`=0, `MemDone`=1, and `MemErr` equals the error flag.
  - The pipeline advances at the end of this cycle. The next state is always IDLE, and the op still visible on the inputs is not re-issued.

Byte lanes, with `a=ALUResult[1:0]`:
- **Byte:** `be=4'b0001<<a`; `wdata={4{StoreData[7:0]}}`.
- **Halfword:** `be = a[1] ? 1100 : 0011`; `wdata={2{StoreData[15:0]}}`.
- **Word:** `be=1111`; `wdata=StoreData`.
- Loads drive `be` identically with `dmem_we`=0.

Load formatting:
- Select the byte or halfword lane of `dmem_rdata` using `a`.
- LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes through.

Illegal-op handling:
- `LoadData` is set to 0 on an error.
- Otherwise `LoadData` holds its value until the next completed load.
- Stores do not modify `LoadData`.

## Timing
- **Reset values:** every output is 0 after reset: `LoadData`, `dmem_*` registers, `MemDone`, `MemErr`. `Stall` is 0 once IDLE is reached.
- **Reset mid-operation:** the state returns to IDLE and `dmem_req` is 0 from the reset edge onward. Memory must tolerate an abandoned request.
- **Latency, legal op:** cycle 0 is IDLE (`Stall`=1), cycle 1 is BUSY (`dmem_req`=1), and `MemDone` occurs 1 cycle after the ack cycle.
  - Zero-wait-state ack (ack in cycle 1) gives DONE in cycle 2: 3 cycles total, 2 stalled.
- **Latency, illegal op:** 2 cycles total (IDLE, then DONE); 1 stalled cycle.
- **Ack outside BUSY:** `dmem_ack` is ignored outside BUSY.
- **Back-to-back ops:** a second memory op arrives in the cycle after DONE and starts from IDLE. There is no bubble beyond the FSM sequence.

## Configuration
- **`LSU_MISALIGN_CHECK_EN` defined:**
  - LH/LHU/SH with `a[0]`=1 is illegal.
  - LW/SW with `a`≠0 is illegal.
  - Illegal ops produce `MemErr` and no memory access.
- **Not defined:** the low address bits that break alignment are ignored.
  - Halfword uses `a[1]` only; word uses lane 0.
  - The access proceeds, and `MemErr` fires only for undefined funct3.

## Test plan
- **SW, zero-wait ack:** SW to 0x104 with data 0xDEADBEEF and ack in the first BUSY cycle. Expect `dmem_addr`=0x104, `be`=1111, `we`=1, `Stall` high for 2 cycles, and `MemDone` in cycle 2.
- **SB then LB, 3 wait states:** SB 0x80 to addr 0x203, then LB from 0x203 with ack after 3 BUSY cycles and rdata 0x80xxxxxx.
  - Expect SB to drive `be`=1000 and `wdata`=0x80808080.
  - Expect LB to return `LoadData`=0xFFFFFF80.
  - Expect `Stall` high for 5 cycles.
- **LHU vs LH:** LHU at 0x302 with rdata 0xABCD1234 gives `LoadData`=0x0000ABCD. LH at 0x302 with the same rdata gives 0xFFFFABCD.
- **Misaligned LW:** LW at 0x101 with `LSU_MISALIGN_CHECK_EN` defined. Expect no `dmem_req`, `MemErr`=`MemDone`=1 in cycle 1, `LoadData`=0, and 1 stalled cycle.
- **Reset in BUSY:** assert `reset` while BUSY with ack withheld. Expect all outputs 0 on the next cycle, then a fresh LW to issue normally.
- **Ack outside BUSY:** pulse `dmem_ack` while IDLE with no op. Expect no state change and `MemDone` to stay 0.
